// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, one bit per
// cycle on operand magnitudes, applying the sign in a final cycle, so every
// operation takes the same number of cycles.
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// divide/remainder ops complete immediately with a zero result.
module muldiv_unit #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] result
);

  localparam int CntW = $clog2(Width + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CntW-1:0]    cnt;    // iterations completed in the current op
  logic [1:0]         op_lo;  // captured op[1:0]; op[2] is implied by state
  logic               neg;    // negate the magnitude result at the end
  logic [Width-1:0]   md;     // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*Width-1:0] p;      // {hi, lo}: product/multiplier or rem/quotient

  // Operand sign handling, evaluated for the op presented at the accepting edge.
  logic             a_signed;
  logic             b_signed;
  logic             a_s;
  logic             b_s;
  logic             neg_in;
  logic [Width-1:0] a_mag;
  logic [Width-1:0] b_mag;

  // Decide signedness per op and take operand magnitudes.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (op[2]) begin
      a_signed = ~op[0];
      b_signed = ~op[0];
    end else begin
      a_signed = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
      b_signed = (op[1:0] == 2'b01);
    end
    a_s   = a_signed & a[Width-1];
    b_s   = b_signed & b[Width-1];
    a_mag = a_s ? -a : a;
    b_mag = b_s ? -b : b;
    if (!op[2]) begin
      neg_in = a_s ^ b_s;
    end else if (op[1]) begin
      neg_in = a_s;                           // remainder follows the dividend
    end else begin
      neg_in = (a_s ^ b_s) & (b != '0);       // x/0 must stay all-ones
    end
  end

  // Shift-add step: add multiplicand into the high half when the multiplier
  // LSB is set, then shift the whole product/multiplier pair right.
  logic [Width:0]     mul_sum;
  logic [2*Width-1:0] mul_next;
  logic [2*Width-1:0] prod;
  logic [Width-1:0]   mul_res;

  always_comb begin
    mul_sum  = {1'b0, p[2*Width-1:Width]} + (p[0] ? {1'b0, md} : '0);
    mul_next = {mul_sum, p[Width-1:1]};
    prod     = neg ? -p : p;
    mul_res  = (op_lo == 2'b00) ? prod[Width-1:0] : prod[2*Width-1:Width];
  end

`ifdef MULDIV_DIV_EN
  // Restoring step: shift the next dividend bit into the remainder, keep the
  // difference if the divisor fits, and shift the quotient bit in at the LSB.
  logic [Width:0]     rem_sh;
  logic [Width:0]     diff;
  logic               fits;
  logic [2*Width-1:0] div_next;
  logic [Width-1:0]   div_mag;
  logic [Width-1:0]   div_res;

  always_comb begin
    rem_sh   = p[2*Width-1:Width-1];
    diff     = rem_sh - {1'b0, md};
    fits     = ~diff[Width];
    div_next = {fits ? diff[Width-1:0] : rem_sh[Width-1:0], p[Width-2:0], fits};
    div_mag  = op_lo[1] ? p[2*Width-1:Width] : p[Width-1:0];
    div_res  = neg ? -div_mag : div_mag;
  end
`endif

  // Status outputs decode directly from the state register.
  always_comb begin
    busy = (state == MUL);
`ifdef MULDIV_DIV_EN
    busy = busy || (state == DIV);
`endif
    done = (state == DONE);
  end

  // Control FSM and datapath registers.
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values, independent of statement order.
  // NOTE: the datapath registers are reset as well as the control state so an
  // aborted operation leaves nothing behind that a later op could observe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_lo  <= '0;
      neg    <= 1'b0;
      md     <= '0;
      p      <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_lo <= op[1:0];
            neg   <= neg_in;
            cnt   <= '0;
            if (!op[2]) begin
              state <= MUL;
              md    <= a_mag;
              p     <= {{Width{1'b0}}, b_mag};
            end else begin
`ifdef MULDIV_DIV_EN
              state <= DIV;
              md    <= b_mag;
              p     <= {{Width{1'b0}}, a_mag};
`else
              state  <= DONE;
              result <= '0;
`endif
            end
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          if (cnt == CntW'(Width)) begin
            state  <= DONE;
            result <= mul_res;
          end else begin
            p   <= mul_next;
            cnt <= cnt + 1'b1;
          end
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          if (cnt == CntW'(Width)) begin
            state  <= DONE;
            result <= div_res;
          end else begin
            p   <= div_next;
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
